// File: rtl/jb_ul_oran_fifo_pkg.sv
// jb_ul_oran_fifo_pkg: shared defaults and level-width helper for the UL O-RAN parameter FIFO.
package jb_ul_oran_fifo_pkg;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_DEPTH  = 32;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ul_oran_fifo_dpram.sv
// ul_oran_fifo_dpram: DATA_W x DEPTH storage, synchronous write, asynchronous read, no reset.
module ul_oran_fifo_dpram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/jb_ul_oran_param_fifo.sv
// jb_ul_oran_param_fifo: parameterised synchronous FIFO with registered status flags,
// error pulses, flush, and standard or first-word-fall-through read mode.
module jb_ul_oran_param_fifo
    import jb_ul_oran_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      write,
    input  logic [DATA_W-1:0]         write_data,
    input  logic                      read,
    output logic [DATA_W-1:0]         read_data,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      full,
    output logic                      almost_full,
    output logic                      empty,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 1024 || AE_LVL >= AF_LVL || AF_LVL > DEPTH) begin : g_bad_param
        $error("jb_ul_oran_param_fifo: illegal DEPTH/AF_LVL/AE_LVL");
    end

    logic [AW-1:0]     r_wptr, r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_full, r_afull, r_empty, r_aempty, r_ovf, r_unf;
    logic              w_wr, w_rd;
    logic [LVL_W-1:0]  w_lvl_nxt;
    logic [DATA_W-1:0] w_mem_q;

    // Full with a simultaneous read still accepts the write; reads never bypass an empty FIFO.
    assign w_wr      = write && (!r_full || read) && !flush;
    assign w_rd      = read && !r_empty && !flush;
    assign w_lvl_nxt = flush ? '0 : r_level + LVL_W'(w_wr) - LVL_W'(w_rd);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wptr   <= flush ? '0 : r_wptr + AW'(w_wr);
            r_rptr   <= flush ? '0 : r_rptr + AW'(w_rd);
            r_level  <= w_lvl_nxt;
            r_full   <= w_lvl_nxt == LVL_W'(DEPTH);
            r_afull  <= w_lvl_nxt >= LVL_W'(AF_LVL);
            r_empty  <= w_lvl_nxt == '0;
            r_aempty <= w_lvl_nxt <= LVL_W'(AE_LVL);
            r_ovf    <= !flush && write && r_full && !read;
            r_unf    <= !flush && read && r_empty;
        end

    ul_oran_fifo_dpram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (write_data),
        .i_raddr (r_rptr),
        .o_rdata (w_mem_q)
    );

    if (FWFT != 0) begin : g_fwft
        assign read_data = w_mem_q;
    end else begin : g_std
        logic [DATA_W-1:0] r_rd_data;
        always_ff @(posedge clk or posedge rst)
            if (rst) r_rd_data <= '0;
            else if (w_rd) r_rd_data <= w_mem_q;
        assign read_data = r_rd_data;
    end

    assign level        = r_level;
    assign full         = r_full;
    assign almost_full  = r_afull;
    assign empty        = r_empty;
    assign almost_empty = r_aempty;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
endmodule
